// File: rtl/canvas_pkg.sv
// Shared constants, types and helpers for the canvas frame-memory write path.
package canvas_pkg;

    localparam int IMAGE_WIDTH  = 320;
    localparam int IMAGE_HEIGHT = 240;
    localparam int X_BITS       = 9;
    localparam int Y_BITS       = 8;
    localparam int COLOR_BITS   = 3;
    localparam int OOB_BITS     = 16;

    typedef struct packed {
        logic [X_BITS-1:0]     x;
        logic [Y_BITS-1:0]     y;
        logic [COLOR_BITS-1:0] color;
    } pixel_req_t;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } arb_state_t;

    function automatic logic in_bounds(
        input logic [X_BITS-1:0] x,
        input logic [Y_BITS-1:0] y,
        input logic [X_BITS-1:0] x_lim,
        input logic [Y_BITS-1:0] y_lim
    );
        return (x < x_lim) && (y < y_lim);
    endfunction

endpackage

// File: rtl/canvas_clear_seq.sv
// Raster sweep for a full-canvas clear: x inner loop, y outer loop, one pixel per cycle.
module canvas_clear_seq
    import canvas_pkg::*;
#(
    parameter int ImageWidth  = IMAGE_WIDTH,
    parameter int ImageHeight = IMAGE_HEIGHT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic [X_BITS-1:0] x,
    output logic [Y_BITS-1:0] y,
    output logic              done
);

    localparam logic [X_BITS-1:0] X_LAST = X_BITS'(ImageWidth - 1);
    localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(ImageHeight - 1);

    arb_state_t state;
    logic       last;

    assign busy = (state == CLEAR);
    assign last = busy && (x == X_LAST) && (y == Y_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            x     <= '0;
            y     <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= CLEAR;
                        x     <= '0;
                        y     <= '0;
                    end
                end
                CLEAR: begin
                    // Counters park on the last pixel rather than wrapping.
                    if (last) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end else if (x == X_LAST) begin
                        x <= '0;
                        y <= y + Y_BITS'(1);
                    end else begin
                        x <= x + X_BITS'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/canvas_write_arbiter.sv
// Sole owner of the frame-memory write port: round-robin CPU/engine arbitration plus canvas clear.
// Optional CANVAS_ARB_OOB_COUNT_EN adds a saturating count of accepted out-of-bounds requests.
module canvas_write_arbiter
    import canvas_pkg::*;
#(
    parameter int ImageWidth  = IMAGE_WIDTH,
    parameter int ImageHeight = IMAGE_HEIGHT,
    parameter int ColorBits   = COLOR_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0_valid,
    input  logic [X_BITS-1:0]    req0_x,
    input  logic [Y_BITS-1:0]    req0_y,
    input  logic [ColorBits-1:0] req0_color,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [X_BITS-1:0]    req1_x,
    input  logic [Y_BITS-1:0]    req1_y,
    input  logic [ColorBits-1:0] req1_color,
    output logic                 req1_ready,
    input  logic                 clear_start,
    input  logic [ColorBits-1:0] clear_color,
    output logic                 clear_busy,
    output logic                 clear_done,
    output logic                 writeEnable,
    output logic [X_BITS-1:0]    XWrite,
    output logic [Y_BITS-1:0]    YWrite,
    output logic [ColorBits-1:0] writeValueMemory
`ifdef CANVAS_ARB_OOB_COUNT_EN
    ,
    output logic [OOB_BITS-1:0]  oob_count
`endif
);

    localparam logic [X_BITS-1:0] X_LIM = X_BITS'(ImageWidth);
    localparam logic [Y_BITS-1:0] Y_LIM = Y_BITS'(ImageHeight);

    logic                 ptr;
    logic [ColorBits-1:0] clear_color_q;
    logic                 start_clear;
    logic                 grant0;
    logic                 grant1;
    logic                 accept;
    logic [X_BITS-1:0]    sel_x;
    logic [Y_BITS-1:0]    sel_y;
    logic [ColorBits-1:0] sel_color;
    logic                 sel_in_bounds;
    logic [X_BITS-1:0]    clr_x;
    logic [Y_BITS-1:0]    clr_y;

    canvas_clear_seq #(
        .ImageWidth (ImageWidth),
        .ImageHeight(ImageHeight)
    ) u_clear_seq (
        .clk  (clk),
        .reset(reset),
        .start(start_clear),
        .busy (clear_busy),
        .x    (clr_x),
        .y    (clr_y),
        .done (clear_done)
    );

    // NOTE: every always_comb output is assigned on every path, so no latches are inferred.
    always_comb begin
        start_clear   = !clear_busy && clear_start;
        // ptr=0 favours req0; clear_start pre-empts both requesters in the same cycle.
        grant0        = reset && !clear_busy && !clear_start && req0_valid && (!req1_valid || !ptr);
        grant1        = reset && !clear_busy && !clear_start && req1_valid && (!req0_valid || ptr);
        accept        = grant0 || grant1;
        sel_x         = grant1 ? req1_x     : req0_x;
        sel_y         = grant1 ? req1_y     : req0_y;
        sel_color     = grant1 ? req1_color : req0_color;
        sel_in_bounds = in_bounds(sel_x, sel_y, X_LIM, Y_LIM);
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr              <= 1'b0;
            clear_color_q    <= '0;
            writeEnable      <= 1'b0;
            XWrite           <= '0;
            YWrite           <= '0;
            writeValueMemory <= '0;
        end else begin
            if (start_clear) clear_color_q <= clear_color;

            if (grant0)      ptr <= 1'b1;
            else if (grant1) ptr <= 1'b0;

            // Address/data hold their last value whenever no write is issued.
            if (clear_busy) begin
                writeEnable      <= 1'b1;
                XWrite           <= clr_x;
                YWrite           <= clr_y;
                writeValueMemory <= clear_color_q;
            end else if (accept && sel_in_bounds) begin
                writeEnable      <= 1'b1;
                XWrite           <= sel_x;
                YWrite           <= sel_y;
                writeValueMemory <= sel_color;
            end else begin
                writeEnable      <= 1'b0;
            end
        end
    end

`ifdef CANVAS_ARB_OOB_COUNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            oob_count <= '0;
        end else if (accept && !sel_in_bounds && (oob_count != '1)) begin
            oob_count <= oob_count + OOB_BITS'(1);
        end
    end
`endif

endmodule

// File: tb/tb_canvas_write_arbiter.sv
// Directed bench for canvas_write_arbiter with a write scoreboard checked on every port write.
module tb_canvas_write_arbiter;
    import canvas_pkg::*;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic                  req0_valid = 1'b0;
    logic [X_BITS-1:0]     req0_x = '0;
    logic [Y_BITS-1:0]     req0_y = '0;
    logic [COLOR_BITS-1:0] req0_color = '0;
    logic                  req0_ready;
    logic                  req1_valid = 1'b0;
    logic [X_BITS-1:0]     req1_x = '0;
    logic [Y_BITS-1:0]     req1_y = '0;
    logic [COLOR_BITS-1:0] req1_color = '0;
    logic                  req1_ready;
    logic                  clear_start = 1'b0;
    logic [COLOR_BITS-1:0] clear_color = '0;
    logic                  clear_busy;
    logic                  clear_done;
    logic                  writeEnable;
    logic [X_BITS-1:0]     XWrite;
    logic [Y_BITS-1:0]     YWrite;
    logic [COLOR_BITS-1:0] writeValueMemory;
`ifdef CANVAS_ARB_OOB_COUNT_EN
    logic [OOB_BITS-1:0]   oob_count;
`endif

    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_writes = 0;
    int         n_done   = 0;
    pixel_req_t exp_q[$];
    pixel_req_t mon_e;
    logic       mon_has;

    always #5 clk = ~clk;

    canvas_write_arbiter dut (
        .clk             (clk),
        .reset           (reset),
        .req0_valid      (req0_valid),
        .req0_x          (req0_x),
        .req0_y          (req0_y),
        .req0_color      (req0_color),
        .req0_ready      (req0_ready),
        .req1_valid      (req1_valid),
        .req1_x          (req1_x),
        .req1_y          (req1_y),
        .req1_color      (req1_color),
        .req1_ready      (req1_ready),
        .clear_start     (clear_start),
        .clear_color     (clear_color),
        .clear_busy      (clear_busy),
        .clear_done      (clear_done),
        .writeEnable     (writeEnable),
        .XWrite          (XWrite),
        .YWrite          (YWrite),
        .writeValueMemory(writeValueMemory)
`ifdef CANVAS_ARB_OOB_COUNT_EN
        ,
        .oob_count       (oob_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    function automatic pixel_req_t mk(input int x, input int y, input int c);
        pixel_req_t p;
        p.x     = X_BITS'(x);
        p.y     = Y_BITS'(y);
        p.color = COLOR_BITS'(c);
        return p;
    endfunction

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic to_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic drain(input string tag, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) to_neg();
        check(tag, exp_q.size(), 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_we"},    writeEnable,      0);
        check({tag, "_x"},     XWrite,           0);
        check({tag, "_y"},     YWrite,           0);
        check({tag, "_data"},  writeValueMemory, 0);
        check({tag, "_busy"},  clear_busy,       0);
        check({tag, "_done"},  clear_done,       0);
        check({tag, "_rdy0"},  req0_ready,       0);
        check({tag, "_rdy1"},  req1_ready,       0);
`ifdef CANVAS_ARB_OOB_COUNT_EN
        check({tag, "_oob"},   oob_count,        0);
`endif
    endtask

    // Scoreboard: every port write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (clear_done === 1'b1) n_done++;
        if (writeEnable === 1'b1) begin
            n_writes++;
            mon_has = (exp_q.size() != 0);
            mon_e   = mon_has ? exp_q.pop_front() : '0;
            check("write", 32'({1'b1, XWrite, YWrite, writeValueMemory}), 32'({mon_has, mon_e}));
        end
    end

    initial begin
        int owner;
        int cyc;
        int bad_ready;
        int base_w;
        int base_d;
        logic done_seen;

        // Reset state.
        repeat (2) to_neg();
        check_idle_outputs("reset");
        reset = 1'b1;

        // Single CPU plot.
        to_pos();
        req0_valid = 1'b1; req0_x = 9'd10; req0_y = 8'd20; req0_color = 3'd5;
        to_neg();
        check("plot_rdy0", req0_ready, 1);
        check("plot_rdy1", req1_ready, 0);
        exp_q.push_back(mk(10, 20, 5));
        to_pos();
        req0_valid = 1'b0;
        to_neg();
        check("plot_we", writeEnable, 1);
        check("plot_x", XWrite, 10);
        to_neg();
        check("plot_we_off", writeEnable, 0);
        check("plot_hold", 32'({XWrite, YWrite, writeValueMemory}), 32'(mk(10, 20, 5)));

        // Round-robin from a fresh reset: grants alternate 0,1,0,1.
        reset = 1'b0;
        to_neg();
        check_idle_outputs("rst2");
        reset = 1'b1;
        to_pos();
        req0_valid = 1'b1; req0_x = 9'd100; req0_y = 8'd1; req0_color = 3'd1;
        req1_valid = 1'b1; req1_x = 9'd200; req1_y = 8'd2; req1_color = 3'd2;
        for (int i = 0; i < 4; i++) begin
            owner = i % 2;
            to_neg();
            check("rr_rdy0", req0_ready, 32'(owner == 0));
            check("rr_rdy1", req1_ready, 32'(owner == 1));
            if (owner == 0) exp_q.push_back(mk(req0_x, req0_y, req0_color));
            else            exp_q.push_back(mk(req1_x, req1_y, req1_color));
            to_pos();
            if (owner == 0) req0_x = req0_x + 9'd1;
            else            req1_x = req1_x + 9'd1;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain("rr_drain", 8);

        // Out-of-bounds requests are accepted but never written.
        to_pos();
        req1_valid = 1'b1; req1_x = 9'd320; req1_y = 8'd0; req1_color = 3'd4;
        to_neg();
        check("oob_x_rdy", req1_ready, 1);
        to_pos();
        req1_x = 9'd0; req1_y = 8'd240;
        to_neg();
        check("oob_y_rdy", req1_ready, 1);
        check("oob_x_we", writeEnable, 0);
        to_pos();
        req1_valid = 1'b0;
        to_neg();
        check("oob_y_we", writeEnable, 0);
`ifdef CANVAS_ARB_OOB_COUNT_EN
        check("oob_count", oob_count, 2);
`endif

        // Full clear, colliding with a CPU request, with a stray clear_start mid-sweep.
        base_w = n_writes;
        base_d = n_done;
        to_pos();
        clear_start = 1'b1; clear_color = 3'd3;
        req0_valid = 1'b1; req0_x = 9'd5; req0_y = 8'd5; req0_color = 3'd1;
        to_neg();
        check("clr_start_rdy0", req0_ready, 0);
        check("clr_start_rdy1", req1_ready, 0);
        for (int yy = 0; yy < IMAGE_HEIGHT; yy++)
            for (int xx = 0; xx < IMAGE_WIDTH; xx++)
                exp_q.push_back(mk(xx, yy, 3));
        to_pos();
        clear_start = 1'b0; clear_color = 3'd0;
        bad_ready = 0;
        done_seen = 1'b0;
        cyc = 0;
        while (!done_seen && cyc < 80000) begin
            to_neg();
            cyc++;
            if (cyc == 1) check("clr_busy", clear_busy, 1);
            if (cyc == 500) begin clear_start = 1'b1; clear_color = 3'd6; end
            if (cyc == 501) begin clear_start = 1'b0; clear_color = 3'd0; end
            if (clear_done === 1'b1) begin
                done_seen = 1'b1;
                check("clr_done_busy", clear_busy, 0);
                check("clr_last", 32'({writeEnable, XWrite, YWrite, writeValueMemory}),
                      32'({1'b1, mk(319, 239, 3)}));
                check("clr_after_rdy0", req0_ready, 1);
                exp_q.push_back(mk(5, 5, 1));
            end else if (req0_ready !== 1'b0) begin
                bad_ready++;
            end
        end
        check("clr_done_seen", done_seen, 1);
        check("clr_rdy_blocked", bad_ready, 0);
        to_pos();
        req0_valid = 1'b0;
        to_neg();
        check("clr_done_pulse", clear_done, 0);
        check("clr_done_count", n_done - base_d, 1);
        check("clr_write_count", n_writes - base_w, IMAGE_WIDTH * IMAGE_HEIGHT + 1);
        drain("clr_drain", 4);

        // Reset in the middle of a clear.
        base_w = n_writes;
        base_d = n_done;
        to_pos();
        clear_start = 1'b1; clear_color = 3'd6;
        to_pos();
        clear_start = 1'b0;
        for (int k = 0; k < 1000; k++) exp_q.push_back(mk(k % IMAGE_WIDTH, k / IMAGE_WIDTH, 6));
        cyc = 0;
        while ((n_writes - base_w) < 1000 && cyc < 2000) begin
            to_neg();
            cyc++;
        end
        check("abort_reached", n_writes - base_w, 1000);
        reset = 1'b0;
        #1;
        check_idle_outputs("abort");
        repeat (3) to_neg();
        check("abort_no_done", n_done - base_d, 0);
        check("abort_queue", exp_q.size(), 0);
        reset = 1'b1;
        to_pos();
        req0_valid = 1'b1; req0_x = 9'd7; req0_y = 8'd8; req0_color = 3'd2;
        to_neg();
        check("post_abort_rdy0", req0_ready, 1);
        check("post_abort_busy", clear_busy, 0);
        exp_q.push_back(mk(7, 8, 2));
        to_pos();
        req0_valid = 1'b0;
        drain("post_abort_drain", 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
